// File: rtl/seg_pkg.sv
// Shared definitions for the score-display path: BCD nibble width, converter
// FSM states and the largest legal decimal digit.
package seg_pkg;

    localparam int BCD_W = 4;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import seg_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    // add-3 correction for one digit
    always_comb begin
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading-zero blank mask on blank).
module bin_to_bcd_seq
    import seg_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     bcd_out,
    output logic                    overflow,
    output logic [DIGITS-1:0]       blank
);

    localparam int SCR_W = BCD_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [31:0] BCD_MAX = 32'(10 ** DIGITS - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [BIN_W-1:0]   shift_r;
    logic [SCR_W-1:0]   scratch_r;
    logic               ovf_pend_r;
    logic               busy_r;
    logic               done_r;
    logic [SCR_W-1:0]   bcd_r;
    logic               ovf_r;

    logic               accept_s;
    logic               last_s;
    logic [SCR_W-1:0]   adj_s;
    logic [SCR_W:0]     shifted_s;
    logic [SCR_W-1:0]   scratch_nxt_s;
    logic [SCR_W-1:0]   final_bcd_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch_r[g*BCD_W +: BCD_W]),
            .dout (adj_s[g*BCD_W +: BCD_W])
        );
    end

    assign shifted_s     = {adj_s, shift_r[BIN_W-1]};
    assign scratch_nxt_s = shifted_s[SCR_W-1:0];
    assign final_bcd_s   = ovf_pend_r ? {DIGITS{DIGIT_MAX}} : scratch_nxt_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM control outputs: accept a new value, or finish on the last shift
    always_comb begin
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            IDLE:    accept_s = start;
            SHIFT:   last_s   = (cnt_r == CNT_LAST);
            default: begin
                accept_s = 1'b0;
                last_s   = 1'b0;
            end
        endcase
    end

    // Shift datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r      <= {CNT_W{1'b0}};
            shift_r    <= {BIN_W{1'b0}};
            scratch_r  <= {SCR_W{1'b0}};
            ovf_pend_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bcd_r      <= {SCR_W{1'b0}};
            ovf_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                shift_r    <= bin_in;
                scratch_r  <= {SCR_W{1'b0}};
                cnt_r      <= {CNT_W{1'b0}};
                ovf_pend_r <= (32'(bin_in) > BCD_MAX);
            end else if (state_r == SHIFT) begin
                shift_r    <= {shift_r[BIN_W-2:0], 1'b0};
                scratch_r  <= scratch_nxt_s;
                cnt_r      <= cnt_r + CNT_W'(1);
                // a carry out of the top digit only happens on overflow, so it
                // just reinforces the saturation decision
                ovf_pend_r <= ovf_pend_r | shifted_s[SCR_W];
            end
            busy_r <= accept_s | (busy_r & ~last_s);
            done_r <= last_s;
            if (last_s) begin
                bcd_r <= final_bcd_s;
                ovf_r <= ovf_pend_r;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign bcd_out  = bcd_r;
    assign overflow = ovf_r;

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_r;

    // digit i blanks when it and every higher digit are zero; units never blank
    function automatic logic [DIGITS-1:0] blank_mask(input logic [SCR_W-1:0] bcd,
                                                     input logic ovf);
        logic [DIGITS-1:0] m;
        logic              zero_run;
        m        = {DIGITS{1'b0}};
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run & (bcd[i*BCD_W +: BCD_W] == 4'd0);
            m[i]     = zero_run;
        end
        return ovf ? {DIGITS{1'b0}} : m;
    endfunction

    // blank mask register, updated with the result
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_r <= {DIGITS{1'b0}};
        end else if (last_s) begin
            blank_r <= blank_mask(final_bcd_s, ovf_pend_r);
        end else begin
            blank_r <= blank_r;
        end
    end

    assign blank = blank_r;
`else
    assign blank = {DIGITS{1'b0}};
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: randomized and directed values checked
// against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;
    logic [3:0]  blank;

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;
    int done_expected = 0;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow),
        .blank    (blank)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int v);
        exp_t e;
        int   r;
        e = '0;
        if (v > 9999) begin
            e.bcd = 16'h9999;
            e.ovf = 1'b1;
        end else begin
            r = v;
            for (int i = 0; i < 4; i++) begin
                e.bcd[i*4 +: 4] = 4'(r % 10);
                r = r / 10;
            end
`ifdef LEADING_ZERO_BLANK_EN
            for (int i = 1; i < 4; i++) begin
                if (v < 10 ** i) e.blank[i] = 1'b1;
            end
`endif
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=%0h expected=none", bcd_out);
            end else begin
                mon_e = sb_q.pop_front();
                check("bcd_out",  32'(bcd_out),  32'(mon_e.bcd));
                check("overflow", 32'(overflow), 32'(mon_e.ovf));
                check("blank",    32'(blank),    32'(mon_e.blank));
            end
        end
    end

    // Issue one conversion at the current negedge (busy must be 0); optionally
    // pulse a stray start at busy cycle glitch_at or reset at cycle reset_at.
    task automatic run_one(input int v, input int glitch_at, input int reset_at);
        int n;
        int bc;
        bit aborted;
        start  = 1'b1;
        bin_in = 14'(v);
        sb_q.push_back(model(v));
        n = 0;
        bc = 0;
        aborted = 1'b0;
        while (1) begin
            @(negedge clk);
            n++;
            start  = 1'b0;
            bin_in = 14'($urandom);
            if (n == glitch_at) begin
                start  = 1'b1;
                bin_in = 14'd42;
            end
            if (done) break;
            if (busy) bc++;
            if (n == reset_at) begin
                reset = 1'b1;
                aborted = 1'b1;
                void'(sb_q.pop_back());
                break;
            end
            if (n >= 40) break;
        end
        if (aborted) begin
            @(negedge clk);
            check("abort_busy",     32'(busy),     32'd0);
            check("abort_done",     32'(done),     32'd0);
            check("abort_bcd",      32'(bcd_out),  32'd0);
            check("abort_overflow", 32'(overflow), 32'd0);
            check("abort_blank",    32'(blank),    32'd0);
            reset = 1'b0;
            repeat (20) @(negedge clk);
            check("abort_idle", 32'(busy), 32'd0);
        end else begin
            done_expected++;
            check("busy_cycles",  32'(bc), 32'(BIN_W));
            check("done_latency", 32'(n),  32'(BIN_W + 1));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = 14'd0;
        repeat (3) @(negedge clk);
        check("reset_busy",     32'(busy),     32'd0);
        check("reset_done",     32'(done),     32'd0);
        check("reset_bcd",      32'(bcd_out),  32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_blank",    32'(blank),    32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_one(1234, 0, 0);
        run_one(0, 0, 0);
        run_one(9999, 0, 0);
        run_one(10000, 0, 0);
        run_one(305, 0, 0);
        run_one(4321, 5, 0);
        run_one(777, 0, 7);
        run_one(16383, 0, 0);
        run_one(1, 0, 0);
        run_one(10, 0, 0);
        run_one(100, 0, 0);
        run_one(1000, 0, 0);
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) run_one(int'($urandom_range(0, 999)), 0, 0);
            else            run_one(int'($urandom_range(0, 16383)), 0, 0);
            if ($urandom_range(0, 3) == 0) repeat (2) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        check("done_count",       32'(done_seen),   32'(done_expected));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
